// File: rtl/calc_engine.sv
// Handshaked multi-cycle unsigned add/sub/mul/div engine.
// Mul is shift-add (LSB of b first); div is restoring (MSB first).
module calc_engine #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic [1:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int RW = 2 * WIDTH;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [RW-1:0]    result_q;
   logic             dbz_q;

   logic             accept;
   logic             handshake;
   logic             last;
   logic             b_zero;
   logic             is_iter;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH-1:0] div_rem;
   logic             div_ok;
   logic [WIDTH-1:0] hi_d;
   logic [WIDTH-1:0] lo_d;

   logic [RW-1:0]    a_x;
   logic [RW-1:0]    b_x;
   logic [RW-1:0]    imm;

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign result      = result_q;
   assign div_by_zero = dbz_q;

   assign accept    = in_valid && in_ready;
   assign handshake = out_valid && out_ready;
   assign last      = (cnt_q == CW'(WIDTH - 1));
   assign b_zero    = (op_b == '0);
   assign is_iter   = (op == OP_MUL) || ((op == OP_DIV) && !b_zero);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = is_iter ? RUN : DONE;
            end
         end
         RUN: begin
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (handshake) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // {hi,lo} is the product (mul) or {remainder,quotient} (div)
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_sh  = {hi_q, lo_q[WIDTH-1]};
      div_ok  = (div_sh >= {1'b0, opnd_q});
      div_rem = div_sh[WIDTH-1:0] - opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (op_q == OP_MUL) begin
         hi_d = mul_sum[WIDTH:1];
         lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else begin
         hi_d = div_ok ? div_rem : div_sh[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], div_ok};
      end
   end

   always_comb begin
      a_x = {{WIDTH{1'b0}}, op_a};
      b_x = {{WIDTH{1'b0}}, op_b};
      imm = '0;
      unique case (1'b1)
         (op == OP_ADD): imm = a_x + b_x;
         (op == OP_SUB): imm = a_x - b_x;
         (op == OP_DIV): imm = {op_a, {WIDTH{1'b1}}};
         default:        imm = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         op_q     <= OP_ADD;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else if (accept) begin
         op_q  <= op;
         cnt_q <= '0;
         hi_q  <= '0;
         dbz_q <= (op == OP_DIV) && b_zero;
         if (op == OP_MUL) begin
            opnd_q <= op_a;
            lo_q   <= op_b;
         end else begin
            opnd_q <= op_b;
            lo_q   <= op_a;
         end
         if (!is_iter) begin
            result_q <= imm;
         end
      end else if (state_q == RUN) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q + CW'(1);
         if (last) begin
            result_q <= {hi_d, lo_d};
         end
      end else if (handshake) begin
         dbz_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_calc_engine.sv
// Randomised self-checking bench for calc_engine.
// Runs a WIDTH=32 and a WIDTH=8 instance against an arithmetic model.
module tb_calc_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic [1:0]  op;
   logic        out_ready;
   int          sel;

   logic        iv32, rdy32, ov32, dz32;
   logic [63:0] r32;
   logic        iv8, rdy8, ov8, dz8;
   logic [15:0] r8;

   logic        rdy_v, ov_v, dz_v;
   logic [63:0] res_v;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign iv32 = iv && (sel == 0);
   assign iv8  = iv && (sel == 1);

   calc_engine #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv32), .in_ready(rdy32),
      .op_a(op_a[31:0]), .op_b(op_b[31:0]), .op(op),
      .out_valid(ov32), .out_ready(out_ready),
      .result(r32), .div_by_zero(dz32)
   );

   calc_engine #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv8), .in_ready(rdy8),
      .op_a(op_a[7:0]), .op_b(op_b[7:0]), .op(op),
      .out_valid(ov8), .out_ready(out_ready),
      .result(r8), .div_by_zero(dz8)
   );

   always_comb begin
      rdy_v = rdy32;
      ov_v  = ov32;
      dz_v  = dz32;
      res_v = r32;
      if (sel == 1) begin
         rdy_v = rdy8;
         ov_v  = ov8;
         dz_v  = dz8;
         res_v = {48'd0, r8};
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {div_by_zero, result} from plain arithmetic
   function automatic logic [64:0] model(input int w, input logic [1:0] o,
                                         input logic [63:0] a,
                                         input logic [63:0] b);
      logic [63:0] wm;
      logic [63:0] rm;
      wm = (64'd1 << w) - 64'd1;
      rm = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
      case (o)
         2'b00: return {1'b0, (a + b) & rm};
         2'b01: return {1'b0, (a - b) & rm};
         2'b10: return {1'b0, (a * b) & rm};
         default: begin
            if (b == 0) return {1'b1, (a << w) | wm};
            return {1'b0, ((a % b) << w) | (a / b)};
         end
      endcase
   endfunction

   task automatic do_cmd(input int w, input logic [1:0] o,
                         input logic [63:0] a_in, input logic [63:0] b_in,
                         input int hold);
      logic [63:0] wm;
      logic [63:0] a;
      logic [63:0] b;
      logic [64:0] exp;
      int          lat;
      int          exp_lat;
      wm  = (64'd1 << w) - 64'd1;
      a   = a_in & wm;
      b   = b_in & wm;
      exp = model(w, o, a, b);
      exp_lat = (o == 2'b10 || (o == 2'b11 && b != 0)) ? w + 1 : 1;
      sel = (w == 32) ? 0 : 1;
      out_ready = 1'b0;
      @(negedge clk);
      check("idle_rdy", 64'(rdy_v), 64'd1);
      op_a = a;
      op_b = b;
      op   = o;
      iv   = 1'b1;
      @(negedge clk);
      lat = 1;
      while (!ov_v && lat < w + 6) begin
         check("busy_rdy", 64'(rdy_v), 64'd0);
         iv   = 1'($urandom);
         op_a = {$urandom, $urandom};
         op_b = {$urandom, $urandom};
         op   = 2'($urandom);
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'(exp_lat));
      check("result", res_v, exp[63:0]);
      check("dbz", 64'(dz_v), 64'(exp[64]));
      for (int i = 0; i < hold; i++) begin
         iv   = 1'(i & 1);
         op_a = {$urandom, $urandom};
         op_b = {$urandom, $urandom};
         @(negedge clk);
         check("bp_result", res_v, exp[63:0]);
         check("bp_valid", 64'(ov_v), 64'd1);
         check("bp_rdy", 64'(rdy_v), 64'd0);
      end
      iv = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("hs_valid", 64'(ov_v), 64'd0);
      check("hs_rdy", 64'(rdy_v), 64'd1);
      check("hs_dbz", 64'(dz_v), 64'd0);
      check("hs_result", res_v, exp[63:0]);
   endtask

   initial begin
      logic        seen;
      logic [63:0] m;
      logic [63:0] a;
      logic [63:0] b;
      int          w;
      rst_n     = 1'b0;
      iv        = 1'b0;
      op_a      = '0;
      op_b      = '0;
      op        = 2'b00;
      out_ready = 1'b0;
      sel       = 0;
      repeat (2) @(negedge clk);
      check("rst_res32", r32, 64'd0);
      check("rst_ov32", 64'(ov32), 64'd0);
      check("rst_dz32", 64'(dz32), 64'd0);
      check("rst_rdy32", 64'(rdy32), 64'd1);
      check("rst_res8", {48'd0, r8}, 64'd0);
      check("rst_rdy8", 64'(rdy8), 64'd1);
      rst_n = 1'b1;

      for (int k = 0; k < 2; k++) begin
         w = (k == 0) ? 32 : 8;
         m = (64'd1 << w) - 64'd1;
         do_cmd(w, 2'b00, 64'd28, 64'd4, 0);
         do_cmd(w, 2'b00, m, 64'd1, 0);
         do_cmd(w, 2'b01, 64'd4, 64'd28, 0);
         do_cmd(w, 2'b01, 64'd28, 64'd4, 0);
         do_cmd(w, 2'b10, m, m, 0);
         do_cmd(w, 2'b10, 64'd0, m, 0);
         do_cmd(w, 2'b11, 64'd28, 64'd4, 0);
         do_cmd(w, 2'b11, 64'd29, 64'd4, 0);
         do_cmd(w, 2'b11, 64'd5, 64'd0, 0);
         do_cmd(w, 2'b11, 64'd3, 64'd9, 0);
         do_cmd(w, 2'b11, m, m, 0);
      end

      do_cmd(32, 2'b11, 64'd29, 64'd4, 10);

      sel = 0;
      @(negedge clk);
      op_a = 64'hFFFF_FFFF;
      op_b = 64'h1234_5678;
      op   = 2'b10;
      iv   = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_res", r32, 64'd0);
      check("mid_rst_ov", 64'(ov32), 64'd0);
      check("mid_rst_dz", 64'(dz32), 64'd0);
      check("mid_rst_rdy", 64'(rdy32), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ov32) seen = 1'b1;
      end
      check("no_ov_after_rst", 64'(seen), 64'd0);
      do_cmd(32, 2'b00, 64'd1, 64'd2, 0);

      for (int i = 0; i < 60; i++) begin
         w = ($urandom_range(0, 1) == 0) ? 32 : 8;
         m = (64'd1 << w) - 64'd1;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: a = m;
            1: b = m;
            2: b = 64'd0;
            3: a = 64'd0;
            4: b = b & 64'hF;
            default: ;
         endcase
         do_cmd(w, 2'($urandom), a, b, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
